// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bip_pkg
//  Description : Shared opcode, mux-select and state encodings for the
//                16-bit accumulator processor control path.
//  Revision    : 1.0 - initial release
// ============================================================================
package bip_pkg;

    localparam int OPC_W   = 5;
    localparam int OPND_W  = 11;
    localparam int OPC_LSB = OPND_W;

    localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SELA_MEM = 2'd0;
    localparam logic [1:0] SELA_EXT = 2'd1;
    localparam logic [1:0] SELA_ALU = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       alu_sub;
        logic       wr_acc;
        logic       mem_rd;
        logic       mem_wr;
        logic       halt;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/bip_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : bip_decoder
//  Description : Combinational opcode decoder producing raw datapath controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output dec_t             ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_HLT:  ctrl.halt = 1'b1;
            OP_STO:  ctrl.mem_wr = 1'b1;
            OP_LD: begin
                ctrl.mem_rd = 1'b1;
                ctrl.sel_a  = SELA_MEM;
                ctrl.wr_acc = 1'b1;
            end
            OP_LDI: begin
                ctrl.sel_a  = SELA_EXT;
                ctrl.wr_acc = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                ctrl.mem_rd  = 1'b1;
                ctrl.sel_a   = SELA_ALU;
                ctrl.sel_b   = 1'b0;
                ctrl.alu_sub = (opcode == OP_SUB);
                ctrl.wr_acc  = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                ctrl.sel_a   = SELA_ALU;
                ctrl.sel_b   = 1'b1;
                ctrl.alu_sub = (opcode == OP_SUBI);
                ctrl.wr_acc  = 1'b1;
            end
            // Unassigned opcodes stop the machine rather than run garbage.
            default: ctrl.halt = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bip_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bip_sequencer
//  Description : Fetch/execute control unit sequencing instruction memory,
//                data memory and the accumulator/ALU datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module bip_sequencer
    import bip_pkg::*;
#(
    parameter int PC_W    = 11,
    parameter int INSTR_W = 16,
    parameter int CYC_W   = 16
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start,
    output logic               o_imem_req,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic               i_imem_valid,
    input  logic [INSTR_W-1:0] i_imem_data,
    output logic [PC_W-1:0]    o_operand,
    output logic [1:0]         o_sel_a,
    output logic               o_sel_b,
    output logic               o_alu_sub,
    output logic               o_wr_acc,
    output logic               o_dmem_req,
    output logic               o_dmem_we,
    input  logic               i_dmem_ready,
    output logic               o_halt,
    output logic [CYC_W-1:0]   o_icount
);

    state_t              r_state;
    state_t              w_next_state;
    logic [PC_W-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [CYC_W-1:0]    r_icount;
    dec_t                w_dec;
    logic                w_load_ir;
    logic                w_retire;
    logic                w_pc_inc;

    bip_decoder u_decoder (
        .opcode (r_ir[INSTR_W-1 -: OPC_W]),
        .ctrl   (w_dec)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_icount <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_ir) begin
                r_ir <= i_imem_data;
            end
            if (w_pc_inc) begin
                r_pc <= r_pc + 1'b1;
            end
            if (w_retire && (r_icount != '1)) begin
                r_icount <= r_icount + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load_ir    = 1'b0;
        w_retire     = 1'b0;
        w_pc_inc     = 1'b0;
        o_imem_req   = 1'b0;
        o_dmem_req   = 1'b0;
        o_dmem_we    = 1'b0;
        o_wr_acc     = 1'b0;
        o_sel_a      = SELA_MEM;
        o_sel_b      = 1'b0;
        o_alu_sub    = 1'b0;
        o_halt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_valid) begin
                    w_load_ir    = 1'b1;
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_dec.halt) begin
                    w_retire     = 1'b1;
                    w_next_state = ST_HALT;
                end else begin
                    o_sel_a   = w_dec.sel_a;
                    o_sel_b   = w_dec.sel_b;
                    o_alu_sub = w_dec.alu_sub;
                    if (w_dec.mem_rd || w_dec.mem_wr) begin
                        o_dmem_req = 1'b1;
                        o_dmem_we  = w_dec.mem_wr;
                        // Memory ops retire only on the cycle the access completes.
                        if (i_dmem_ready) begin
                            o_wr_acc     = w_dec.wr_acc;
                            w_retire     = 1'b1;
                            w_pc_inc     = 1'b1;
                            w_next_state = ST_FETCH;
                        end
                    end else begin
                        o_wr_acc     = w_dec.wr_acc;
                        w_retire     = 1'b1;
                        w_pc_inc     = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                o_halt = 1'b1;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign o_imem_addr = r_pc;
    assign o_operand   = r_ir[PC_W-1:0];
    assign o_icount    = r_icount;

endmodule
`default_nettype wire
